// File: rtl/hysteresis_trigger.sv
// Debounced hysteresis comparator driving the SET/RST command pair of the feedback register.
// Optional periodic command re-issue is compiled in with `define HYST_REFRESH_EN.
module hysteresis_trigger #(
   parameter int DATA_W         = 12,
   parameter int DEBOUNCE       = 4,
   parameter int REFRESH_PERIOD = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic [DATA_W-1:0] thr_hi,
   input  logic [DATA_W-1:0] thr_lo,
   output logic              SET,
   output logic              RST,
   output logic              level,
   output logic              cfg_err,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      LOW    = 2'd0,
      ARM_HI = 2'd1,
      HIGH   = 2'd2,
      ARM_LO = 2'd3
   } state_t;

   localparam logic [7:0] DEB = 8'(DEBOUNCE);

   if (DEBOUNCE < 1 || DEBOUNCE > 255 || REFRESH_PERIOD < 2 || REFRESH_PERIOD > 65535) begin : g_bad_params
      $error("hysteresis_trigger: DEBOUNCE or REFRESH_PERIOD out of range");
   end

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;
   logic       cmd_set, cmd_clr, cmd_ref;
   logic       qual, above, below;

   // Handshake: sample_data is consumed only on cycles where sample_valid is high;
   // there is no backpressure, the block always accepts a valid sample.
   assign qual      = en & sample_valid & ~cfg_err;
   assign above     = sample_data > thr_hi;
   assign below     = sample_data < thr_lo;
   assign state_dbg = state;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cmd_set = 1'b0;
      cmd_clr = 1'b0;
      if (cfg_err) begin
         // Bad thresholds abandon any arming sequence in progress.
         if (state == ARM_HI) begin
            state_n = LOW;
            cnt_n   = 8'd0;
         end else if (state == ARM_LO) begin
            state_n = HIGH;
            cnt_n   = 8'd0;
         end
      end else if (qual) begin
         case (state)
            LOW: begin
               if (above) begin
                  if (DEB == 8'd1) begin
                     cmd_set = 1'b1;
                     state_n = HIGH;
                     cnt_n   = 8'd0;
                  end else begin
                     state_n = ARM_HI;
                     cnt_n   = 8'd1;
                  end
               end
            end
            ARM_HI: begin
               if (above) begin
                  if (8'(cnt + 8'd1) == DEB) begin
                     cmd_set = 1'b1;
                     state_n = HIGH;
                     cnt_n   = 8'd0;
                  end else begin
                     cnt_n = 8'(cnt + 8'd1);
                  end
               end else begin
                  state_n = LOW;
                  cnt_n   = 8'd0;
               end
            end
            HIGH: begin
               if (below) begin
                  if (DEB == 8'd1) begin
                     cmd_clr = 1'b1;
                     state_n = LOW;
                     cnt_n   = 8'd0;
                  end else begin
                     state_n = ARM_LO;
                     cnt_n   = 8'd1;
                  end
               end
            end
            ARM_LO: begin
               if (below) begin
                  if (8'(cnt + 8'd1) == DEB) begin
                     cmd_clr = 1'b1;
                     state_n = LOW;
                     cnt_n   = 8'd0;
                  end else begin
                     cnt_n = 8'(cnt + 8'd1);
                  end
               end else begin
                  state_n = HIGH;
                  cnt_n   = 8'd0;
               end
            end
            default: begin
               state_n = LOW;
               cnt_n   = 8'd0;
            end
         endcase
      end
   end

`ifdef HYST_REFRESH_EN
   localparam logic [15:0] REF_LAST = 16'(REFRESH_PERIOD - 1);

   logic [15:0] ref_cnt, ref_cnt_n;

   // Level changes take priority; the refresh counter only runs in the settled states.
   always_comb begin
      ref_cnt_n = ref_cnt;
      cmd_ref   = 1'b0;
      if (cmd_set || cmd_clr || state == ARM_HI || state == ARM_LO) begin
         ref_cnt_n = 16'd0;
      end else if (en && !cfg_err) begin
         if (ref_cnt == REF_LAST) begin
            cmd_ref   = 1'b1;
            ref_cnt_n = 16'd0;
         end else begin
            ref_cnt_n = ref_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) ref_cnt <= 16'd0;
      else        ref_cnt <= ref_cnt_n;
   end
`else
   assign cmd_ref = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= LOW;
         cnt     <= 8'd0;
         SET     <= 1'b1;
         RST     <= 1'b0;
         level   <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         cfg_err <= thr_lo > thr_hi;
         if (cmd_set) begin
            SET   <= 1'b1;
            RST   <= 1'b1;
            level <= 1'b1;
         end else if (cmd_clr) begin
            SET   <= 1'b0;
            RST   <= 1'b0;
            level <= 1'b0;
         end else if (cmd_ref) begin
            // Re-issued command mirrors the current level: 11 loads 1, 00 loads 0.
            SET <= level;
            RST <= level;
         end else begin
            SET <= 1'b1;
            RST <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hysteresis_trigger.sv
// Directed bench for hysteresis_trigger: DATA_W=12, DEBOUNCE=4, REFRESH_PERIOD=8.
// Outputs are checked 1 ns after each rising edge; inputs change at the same point.
module tb_hysteresis_trigger;

   localparam int DATA_W = 12;
   localparam logic [1:0] S_LOW = 2'd0, S_ARM_HI = 2'd1, S_HIGH = 2'd2, S_ARM_LO = 2'd3;
   // {SET,RST,level} codes
   localparam logic [2:0] HOLD0 = 3'b100, HOLD1 = 3'b101, SETP = 3'b111, CLRP = 3'b000;

   logic              clk = 1'b0;
   logic              reset, en, sample_valid;
   logic [DATA_W-1:0] sample_data, thr_hi, thr_lo;
   logic              SET, RST, level, cfg_err;
   logic [1:0]        state_dbg;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   hysteresis_trigger #(
      .DATA_W(DATA_W),
      .DEBOUNCE(4),
      .REFRESH_PERIOD(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .sample_valid(sample_valid),
      .sample_data(sample_data),
      .thr_hi(thr_hi),
      .thr_lo(thr_lo),
      .SET(SET),
      .RST(RST),
      .level(level),
      .cfg_err(cfg_err),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sample(input logic v, input logic [DATA_W-1:0] d);
      sample_valid = v;
      sample_data  = d;
      tick();
   endtask

   initial begin
      logic [2:0] exp_o;
      reset        = 1'b0;
      en           = 1'b1;
      sample_valid = 1'b0;
      sample_data  = '0;
      thr_hi       = 12'd100;
      thr_lo       = 12'd50;

      // Reset state
      tick();
      tick();
      chk("rst_out", {5'd0, SET, RST, level}, {5'd0, HOLD0});
      chk("rst_cfg", {7'd0, cfg_err}, 8'd0);
      chk("rst_state", {6'd0, state_dbg}, {6'd0, S_LOW});
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_hold", {5'd0, SET, RST, level}, {5'd0, HOLD0});
      end

      // Four above samples -> one set pulse
      for (int i = 0; i < 3; i++) begin
         sample(1'b1, 12'd120);
         chk("rise_arm", {5'd0, SET, RST, level}, {5'd0, HOLD0});
      end
      chk("rise_state", {6'd0, state_dbg}, {6'd0, S_ARM_HI});
      sample(1'b1, 12'd120);
      chk("rise_pulse", {5'd0, SET, RST, level}, {5'd0, SETP});
      chk("rise_high", {6'd0, state_dbg}, {6'd0, S_HIGH});
      sample(1'b0, 12'd0);
      chk("rise_after", {5'd0, SET, RST, level}, {5'd0, HOLD1});

      // In-band 75 breaks the fall sequence
      sample(1'b1, 12'd30);
      chk("fall_a", {5'd0, SET, RST, level}, {5'd0, HOLD1});
      sample(1'b1, 12'd30);
      chk("fall_b", {5'd0, SET, RST, level}, {5'd0, HOLD1});
      sample(1'b1, 12'd75);
      chk("fall_band_state", {6'd0, state_dbg}, {6'd0, S_HIGH});
      for (int i = 0; i < 3; i++) begin
         sample(1'b1, 12'd30);
         chk("fall_rearm", {5'd0, SET, RST, level}, {5'd0, HOLD1});
      end
      sample(1'b1, 12'd30);
      chk("fall_pulse", {5'd0, SET, RST, level}, {5'd0, CLRP});
      chk("fall_low", {6'd0, state_dbg}, {6'd0, S_LOW});
      sample(1'b0, 12'd0);
      chk("fall_after", {5'd0, SET, RST, level}, {5'd0, HOLD0});

      // Invalid gaps do not break debounce
      sample(1'b1, 12'd120);
      sample(1'b0, 12'd0);
      sample(1'b0, 12'd0);
      sample(1'b1, 12'd120);
      sample(1'b0, 12'd0);
      sample(1'b1, 12'd120);
      sample(1'b0, 12'd0);
      chk("gap_hold", {5'd0, SET, RST, level}, {5'd0, HOLD0});
      chk("gap_state", {6'd0, state_dbg}, {6'd0, S_ARM_HI});
      sample(1'b1, 12'd120);
      chk("gap_pulse", {5'd0, SET, RST, level}, {5'd0, SETP});
      sample(1'b0, 12'd0);
      chk("gap_after", {5'd0, SET, RST, level}, {5'd0, HOLD1});

      // en=0 freezes
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sample(1'b1, 12'd10);
         chk("en_off", {5'd0, SET, RST, level}, {5'd0, HOLD1});
      end
      chk("en_off_state", {6'd0, state_dbg}, {6'd0, S_HIGH});
      en = 1'b1;

      // Inverted thresholds -> cfg_err, all samples ignored
      thr_lo = 12'd200;
      sample(1'b0, 12'd0);
      chk("cfg_err_set", {7'd0, cfg_err}, 8'd1);
      for (int i = 0; i < 10; i++) begin
         sample(1'b1, 12'd250);
         chk("cfg_hi", {5'd0, SET, RST, level}, {5'd0, HOLD1});
      end
      for (int i = 0; i < 4; i++) begin
         sample(1'b1, 12'd10);
         chk("cfg_lo", {5'd0, SET, RST, level}, {5'd0, HOLD1});
      end
      chk("cfg_state", {6'd0, state_dbg}, {6'd0, S_HIGH});
      thr_lo = 12'd50;
      sample(1'b0, 12'd0);
      chk("cfg_err_clr", {7'd0, cfg_err}, 8'd0);

      // cfg_err rising during ARM_LO aborts back to HIGH
      sample(1'b1, 12'd30);
      chk("abort_arm", {6'd0, state_dbg}, {6'd0, S_ARM_LO});
      thr_lo = 12'd200;
      sample(1'b0, 12'd0);
      sample(1'b0, 12'd0);
      chk("abort_state", {6'd0, state_dbg}, {6'd0, S_HIGH});
      thr_lo = 12'd50;
      sample(1'b0, 12'd0);
      // Debounce restarts from zero after the abort
      for (int i = 0; i < 3; i++) begin
         sample(1'b1, 12'd30);
         chk("abort_rearm", {5'd0, SET, RST, level}, {5'd0, HOLD1});
      end
      sample(1'b1, 12'd30);
      chk("abort_pulse", {5'd0, SET, RST, level}, {5'd0, CLRP});
      sample(1'b0, 12'd0);

      // Reset mid-ARM_HI
      sample(1'b1, 12'd120);
      sample(1'b1, 12'd120);
      chk("mid_arm", {6'd0, state_dbg}, {6'd0, S_ARM_HI});
      reset = 1'b0;
      sample(1'b1, 12'd120);
      chk("mid_rst_state", {6'd0, state_dbg}, {6'd0, S_LOW});
      chk("mid_rst_out", {5'd0, SET, RST, level}, {5'd0, HOLD0});
      reset = 1'b1;
      sample(1'b0, 12'd0);
      for (int i = 0; i < 3; i++) begin
         sample(1'b1, 12'd120);
         chk("post_rst_arm", {5'd0, SET, RST, level}, {5'd0, HOLD0});
      end
      sample(1'b1, 12'd120);
      chk("post_rst_pulse", {5'd0, SET, RST, level}, {5'd0, SETP});

      // Steady level=1: refresh pulses every 8 cycles only when compiled in
      sample_valid = 1'b0;
`ifdef HYST_REFRESH_EN
      for (int k = 1; k <= 40; k++) begin
         tick();
         exp_o = (k % 8 == 0) ? SETP : HOLD1;
         chk("refresh", {5'd0, SET, RST, level}, {5'd0, exp_o});
      end
`else
      for (int k = 1; k <= 100; k++) begin
         tick();
         exp_o = HOLD1;
         chk("no_refresh", {5'd0, SET, RST, level}, {5'd0, exp_o});
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
